// File: rtl/axil_sim_ctrl_pkg.sv
// Shared register offsets, AXI response codes and FSM state types for axil_sim_ctrl.
package axil_sim_ctrl_pkg;

    localparam logic [3:0] OFS_CTRL   = 4'h0;
    localparam logic [3:0] OFS_SIG    = 4'h4;
    localparam logic [3:0] OFS_STATUS = 4'h8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_EXEC,
        WR_RESP
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_DATA
    } rd_state_t;

endpackage

// File: rtl/sim_ctrl_fifo.sv
// Synchronous FIFO for signature words; push and pop in one cycle are both honoured, even when full.
module sim_ctrl_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    // Storage is not reset: pointers and count alone define the contents.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/axil_sim_ctrl.sv
// AXI4-Lite simulation control slave: signature FIFO, halt request, optional watchdog.
// Define AXIL_SIM_CTRL_TIMEOUT_EN to build the watchdog counter and TIMEOUT flag.
module axil_sim_ctrl
    import axil_sim_ctrl_pkg::*;
#(
    parameter int unsigned            AXI_AWIDTH     = 32,
    parameter int unsigned            AXI_DWIDTH     = 32,
    parameter logic [AXI_AWIDTH-1:0]  BASE_ADDR      = 32'hF000_0000,
    parameter int unsigned            FIFO_DEPTH     = 16,
    parameter logic [AXI_DWIDTH-1:0]  HALT_CODE      = 32'hCAFE_CAFE,
    parameter int unsigned            TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [AXI_AWIDTH-1:0]     AXI_AWADDR,
    input  logic                      AXI_AWVALID,
    output logic                      AXI_AWREADY,
    input  logic [AXI_DWIDTH-1:0]     AXI_WDATA,
    input  logic [AXI_DWIDTH/8-1:0]   AXI_WSTRB,
    input  logic                      AXI_WVALID,
    output logic                      AXI_WREADY,
    output logic [1:0]                AXI_BRESP,
    output logic                      AXI_BVALID,
    input  logic                      AXI_BREADY,
    input  logic [AXI_AWIDTH-1:0]     AXI_ARADDR,
    input  logic                      AXI_ARVALID,
    output logic                      AXI_ARREADY,
    output logic [AXI_DWIDTH-1:0]     AXI_RDATA,
    output logic [1:0]                AXI_RRESP,
    output logic                      AXI_RVALID,
    input  logic                      AXI_RREADY,
    output logic [AXI_DWIDTH-1:0]     SIG_DATA,
    output logic                      SIG_VALID,
    input  logic                      SIG_READY,
    output logic                      HALT,
    output logic                      TIMEOUT
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    wr_state_t                 wr_state;
    rd_state_t                 rd_state;
    logic                      aw_held;
    logic                      w_held;
    logic [AXI_AWIDTH-1:0]     aw_addr;
    logic [AXI_DWIDTH-1:0]     w_data;
    logic [AXI_DWIDTH/8-1:0]   w_strb;
    logic                      halt_req;
    logic                      halt_set;
    logic                      timeout_hit;
    logic                      timeout_q;
    logic                      wr_stall;
    logic [1:0]                wr_resp;
    logic [AXI_DWIDTH-1:0]     rd_word;
    logic [1:0]                rd_resp;
    logic                      fifo_push;
    logic                      fifo_pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [CW-1:0]             fifo_count;

    sim_ctrl_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (AXI_DWIDTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (w_data),
        .dout  (SIG_DATA),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign SIG_VALID = !fifo_empty;
    assign fifo_pop  = !fifo_empty && SIG_READY;

    // A full FIFO still accepts the push when a pop happens in the same cycle.
    always_comb begin
        fifo_push = 1'b0;
        halt_set  = 1'b0;
        wr_stall  = 1'b0;
        wr_resp   = RESP_OKAY;
        if (wr_state == WR_EXEC) begin
            if (aw_addr[AXI_AWIDTH-1:4] != BASE_ADDR[AXI_AWIDTH-1:4] || w_strb != '1) begin
                wr_resp = RESP_SLVERR;
            end else begin
                case (aw_addr[3:0])
                    OFS_CTRL: halt_set = (w_data == HALT_CODE);
                    OFS_SIG: begin
                        if (halt_req)                     wr_resp   = RESP_SLVERR;
                        else if (fifo_full && !fifo_pop)  wr_stall  = 1'b1;
                        else                              fifo_push = 1'b1;
                    end
                    default: wr_resp = RESP_SLVERR;
                endcase
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_state    <= WR_IDLE;
            AXI_AWREADY <= 1'b0;
            AXI_WREADY  <= 1'b0;
            AXI_BVALID  <= 1'b0;
            AXI_BRESP   <= RESP_OKAY;
            aw_held     <= 1'b0;
            w_held      <= 1'b0;
            aw_addr     <= '0;
            w_data      <= '0;
            w_strb      <= '0;
        end else begin
            case (wr_state)
                WR_IDLE: begin
                    if (AXI_AWVALID && AXI_AWREADY) begin
                        aw_addr <= AXI_AWADDR;
                        aw_held <= 1'b1;
                    end
                    if (AXI_WVALID && AXI_WREADY) begin
                        w_data <= AXI_WDATA;
                        w_strb <= AXI_WSTRB;
                        w_held <= 1'b1;
                    end
                    AXI_AWREADY <= !(aw_held || (AXI_AWVALID && AXI_AWREADY));
                    AXI_WREADY  <= !(w_held || (AXI_WVALID && AXI_WREADY));
                    if (aw_held && w_held) wr_state <= WR_EXEC;
                end
                WR_EXEC: begin
                    if (!wr_stall) begin
                        AXI_BRESP  <= wr_resp;
                        AXI_BVALID <= 1'b1;
                        aw_held    <= 1'b0;
                        w_held     <= 1'b0;
                        wr_state   <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (AXI_BREADY) begin
                        AXI_BVALID  <= 1'b0;
                        AXI_AWREADY <= 1'b1;
                        AXI_WREADY  <= 1'b1;
                        wr_state    <= WR_IDLE;
                    end
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_word = '0;
        rd_resp = RESP_OKAY;
        if (AXI_ARADDR[AXI_AWIDTH-1:4] != BASE_ADDR[AXI_AWIDTH-1:4]) begin
            rd_resp = RESP_SLVERR;
        end else begin
            case (AXI_ARADDR[3:0])
                OFS_CTRL:   rd_word[0] = halt_req;
                OFS_SIG:    ;
                OFS_STATUS: rd_word = {16'b0, 8'(fifo_count), 6'b0, timeout_q, halt_req};
                default:    rd_resp = RESP_SLVERR;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_state    <= RD_IDLE;
            AXI_ARREADY <= 1'b0;
            AXI_RVALID  <= 1'b0;
            AXI_RDATA   <= '0;
            AXI_RRESP   <= RESP_OKAY;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    AXI_ARREADY <= 1'b1;
                    if (AXI_ARVALID && AXI_ARREADY) begin
                        AXI_RDATA   <= rd_word;
                        AXI_RRESP   <= rd_resp;
                        AXI_RVALID  <= 1'b1;
                        AXI_ARREADY <= 1'b0;
                        rd_state    <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (AXI_RREADY) begin
                        AXI_RVALID  <= 1'b0;
                        AXI_ARREADY <= 1'b1;
                        rd_state    <= RD_IDLE;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            halt_req <= 1'b0;
            HALT     <= 1'b0;
        end else begin
            halt_req <= halt_req | halt_set | timeout_hit;
            HALT     <= HALT | (halt_req && fifo_empty && wr_state == WR_IDLE);
        end
    end

`ifdef AXIL_SIM_CTRL_TIMEOUT_EN
    logic [31:0] wd_cnt;

    assign timeout_hit = !timeout_q && !HALT && (wd_cnt == TIMEOUT_CYCLES - 1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (!HALT)       wd_cnt    <= wd_cnt + 32'd1;
            if (timeout_hit) timeout_q <= 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
    assign timeout_q          = 1'b0;
`endif

    assign TIMEOUT = timeout_q;

endmodule

// File: tb/tb_axil_sim_ctrl.sv
// Directed self-checking bench for axil_sim_ctrl (watchdog scenario runs when AXIL_SIM_CTRL_TIMEOUT_EN is defined).
module tb_axil_sim_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] sig_data;
    logic        sig_valid;
    logic        sig_ready;
    logic        halt;
    logic        timeout;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] sig_q[$];

    always #5 clk = ~clk;

    axil_sim_ctrl #(
        .TIMEOUT_CYCLES (100)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .AXI_AWADDR  (awaddr),
        .AXI_AWVALID (awvalid),
        .AXI_AWREADY (awready),
        .AXI_WDATA   (wdata),
        .AXI_WSTRB   (wstrb),
        .AXI_WVALID  (wvalid),
        .AXI_WREADY  (wready),
        .AXI_BRESP   (bresp),
        .AXI_BVALID  (bvalid),
        .AXI_BREADY  (bready),
        .AXI_ARADDR  (araddr),
        .AXI_ARVALID (arvalid),
        .AXI_ARREADY (arready),
        .AXI_RDATA   (rdata),
        .AXI_RRESP   (rresp),
        .AXI_RVALID  (rvalid),
        .AXI_RREADY  (rready),
        .SIG_DATA    (sig_data),
        .SIG_VALID   (sig_valid),
        .SIG_READY   (sig_ready),
        .HALT        (halt),
        .TIMEOUT     (timeout)
    );

    // Words consumed by the signature writer.
    always @(negedge clk) begin
        if (!rst && sig_valid && sig_ready) sig_q.push_back(sig_data);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly,
                             output logic [1:0] resp, output int lat);
        bit aw_done = 0;
        bit w_done  = 0;
        bit aw_hs;
        bit w_hs;
        int c = 0;
        lat = -1;
        resp = 2'bxx;
        awaddr = a;
        wdata = d;
        wstrb = s;
        while (!(aw_done && w_done) && c < 100) begin
            awvalid = !aw_done && c >= aw_dly;
            wvalid  = !w_done && c >= w_dly;
            aw_hs   = awvalid && awready;
            w_hs    = wvalid && wready;
            step();
            if (aw_hs) aw_done = 1;
            if (w_hs)  w_done = 1;
            c++;
        end
        awvalid = 0;
        wvalid = 0;
        bready = 1;
        for (int k = 0; k < 50; k++) begin
            if (bvalid) begin
                lat = k;
                resp = bresp;
                step();
                break;
            end
            step();
        end
        bready = 0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d,
                            output logic [1:0] resp, output bit prompt);
        bit hs;
        d = 'x;
        resp = 2'bxx;
        prompt = 0;
        araddr = a;
        arvalid = 1;
        for (int c = 0; c < 50; c++) begin
            hs = arready;
            step();
            if (hs) break;
        end
        arvalid = 0;
        prompt = rvalid;
        rready = 1;
        for (int k = 0; k < 50; k++) begin
            if (rvalid) begin
                d = rdata;
                resp = rresp;
                step();
                break;
            end
            step();
        end
        rready = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        step();
        step();
        n_checks++;
        if ({awready, wready, bvalid, arready, rvalid, sig_valid, halt, timeout} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 00000000",
                     {awready, wready, bvalid, arready, rvalid, sig_valid, halt, timeout});
        end
        n_checks++;
        if ({bresp, rresp, rdata} !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_data: bresp %b rresp %b rdata %h expected all 0", bresp, rresp, rdata);
        end
        rst = 0;
        step();
        step();
    endtask

    task automatic test_sig();
        logic [1:0] r;
        int         lat;
        sig_ready = 1;
        sig_q.delete();
        axi_write(32'hF000_0004, 32'h1111_1111, 4'hF, 0, 0, r, lat);
        n_checks++;
        if (r !== 2'b00) begin n_fail++; $display("FAIL sig_w1_resp: got %b expected 00", r); end
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL sig_w1_latency: got %0d expected 2", lat); end
        axi_write(32'hF000_0004, 32'h2222_2222, 4'hF, 0, 0, r, lat);
        n_checks++;
        if (r !== 2'b00) begin n_fail++; $display("FAIL sig_w2_resp: got %b expected 00", r); end
        repeat (4) step();
        n_checks++;
        if (sig_q.size() !== 2) begin
            n_fail++; $display("FAIL sig_count: got %0d expected 2", sig_q.size());
        end else begin
            n_checks++;
            if (sig_q[0] !== 32'h1111_1111 || sig_q[1] !== 32'h2222_2222) begin
                n_fail++;
                $display("FAIL sig_order: got %h %h expected 11111111 22222222", sig_q[0], sig_q[1]);
            end
        end
    endtask

    task automatic test_ordering();
        logic [1:0]  r;
        logic [31:0] d;
        bit          p;
        int          lat;
        sig_ready = 1;
        sig_q.delete();
        axi_write(32'hF000_0004, 32'hA000_0001, 4'hF, 0, 3, r, lat);
        n_checks++;
        if (r !== 2'b00) begin n_fail++; $display("FAIL aw_first_resp: got %b expected 00", r); end
        axi_write(32'hF000_0004, 32'hA000_0002, 4'hF, 2, 0, r, lat);
        n_checks++;
        if (r !== 2'b00) begin n_fail++; $display("FAIL w_first_resp: got %b expected 00", r); end
        axi_write(32'hF000_0004, 32'hA000_0003, 4'hF, 0, 0, r, lat);
        n_checks++;
        if (r !== 2'b00) begin n_fail++; $display("FAIL same_cycle_resp: got %b expected 00", r); end
        repeat (3) step();
        n_checks++;
        if (sig_q.size() !== 3) begin
            n_fail++; $display("FAIL order_count: got %0d expected 3", sig_q.size());
        end else begin
            n_checks++;
            if (sig_q[0] !== 32'hA000_0001 || sig_q[2] !== 32'hA000_0003) begin
                n_fail++; $display("FAIL order_data: got %h %h expected a0000001 a0000003", sig_q[0], sig_q[2]);
            end
        end
        axi_write(32'hF000_0004, 32'h3333_3333, 4'h3, 0, 0, r, lat);
        n_checks++;
        if (r !== 2'b10) begin n_fail++; $display("FAIL wstrb_resp: got %b expected 10", r); end
        repeat (3) step();
        n_checks++;
        if (sig_q.size() !== 3) begin n_fail++; $display("FAIL wstrb_no_push: got %0d expected 3", sig_q.size()); end
        axi_read(32'hF000_0008, d, r, p);
        n_checks++;
        if (d !== 32'h0000_0000 || r !== 2'b00) begin
            n_fail++; $display("FAIL wstrb_status: got %h/%b expected 00000000/00", d, r);
        end
    endtask

    task automatic test_backpressure();
        logic [1:0]  r;
        logic [31:0] d;
        bit          p;
        bit          aw_done;
        bit          w_done;
        bit          seen;
        int          lat;
        sig_ready = 0;
        sig_q.delete();
        for (int i = 0; i < 16; i++) begin
            axi_write(32'hF000_0004, 32'h100 + i, 4'hF, 0, 0, r, lat);
            n_checks++;
            if (r !== 2'b00) begin n_fail++; $display("FAIL fill_resp[%0d]: got %b expected 00", i, r); end
        end
        axi_read(32'hF000_0008, d, r, p);
        n_checks++;
        if (d !== 32'h0000_1000) begin n_fail++; $display("FAIL full_status: got %h expected 00001000", d); end
        awaddr = 32'hF000_0004;
        wdata = 32'h110;
        wstrb = 4'hF;
        awvalid = 1;
        wvalid = 1;
        aw_done = 0;
        w_done = 0;
        for (int c = 0; c < 20 && !(aw_done && w_done); c++) begin
            if (awvalid && awready) aw_done = 1;
            if (wvalid && wready)   w_done = 1;
            step();
            if (aw_done) awvalid = 0;
            if (w_done)  wvalid = 0;
        end
        awvalid = 0;
        wvalid = 0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (bvalid) seen = 1;
            step();
        end
        n_checks++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL full_bvalid_held: got %b expected 0", seen); end
        sig_ready = 1;
        step();
        sig_ready = 0;
        seen = 0;
        for (int c = 0; c < 3 && !seen; c++) begin
            if (bvalid) seen = 1;
            else step();
        end
        n_checks++;
        if (seen !== 1'b1 || bresp !== 2'b00) begin
            n_fail++; $display("FAIL pop_releases_b: bvalid %b bresp %b expected 1/00", seen, bresp);
        end
        bready = 1;
        step();
        bready = 0;
        sig_ready = 1;
        repeat (20) step();
        n_checks++;
        if (sig_q.size() !== 17) begin
            n_fail++; $display("FAIL drain_count: got %0d expected 17", sig_q.size());
        end else begin
            n_checks++;
            if (sig_q[0] !== 32'h100 || sig_q[15] !== 32'h10F || sig_q[16] !== 32'h110) begin
                n_fail++;
                $display("FAIL drain_data: got %h %h %h expected 00000100 0000010f 00000110",
                         sig_q[0], sig_q[15], sig_q[16]);
            end
        end
    endtask

    task automatic test_decode();
        logic [1:0]  r;
        logic [31:0] d;
        bit          p;
        int          lat;
        sig_ready = 1;
        sig_q.delete();
        axi_read(32'hF000_000C, d, r, p);
        n_checks++;
        if (r !== 2'b10 || d !== 32'h0) begin n_fail++; $display("FAIL rd_bad_ofs: got %h/%b expected 00000000/10", d, r); end
        n_checks++;
        if (p !== 1'b1) begin n_fail++; $display("FAIL rd_latency: rvalid %b expected 1 after accept", p); end
        axi_write(32'hE000_0004, 32'h55, 4'hF, 0, 0, r, lat);
        n_checks++;
        if (r !== 2'b10) begin n_fail++; $display("FAIL wr_bad_base: got %b expected 10", r); end
        axi_write(32'hF000_0000, 32'h1234_5678, 4'hF, 0, 0, r, lat);
        n_checks++;
        if (r !== 2'b00) begin n_fail++; $display("FAIL ctrl_other_resp: got %b expected 00", r); end
        repeat (3) step();
        n_checks++;
        if (sig_q.size() !== 0) begin n_fail++; $display("FAIL bad_base_no_push: got %0d expected 0", sig_q.size()); end
        axi_read(32'hF000_0000, d, r, p);
        n_checks++;
        if (d !== 32'h0 || r !== 2'b00) begin n_fail++; $display("FAIL ctrl_not_halted: got %h/%b expected 00000000/00", d, r); end
    endtask

    task automatic test_halt();
        logic [1:0]  r;
        logic [31:0] d;
        bit          p;
        bit          found;
        int          lat;
        sig_ready = 0;
        sig_q.delete();
        for (int i = 1; i <= 3; i++) begin
            axi_write(32'hF000_0004, 32'hB0 + i, 4'hF, 0, 0, r, lat);
        end
        axi_write(32'hF000_0000, 32'hCAFE_CAFE, 4'hF, 0, 0, r, lat);
        n_checks++;
        if (r !== 2'b00) begin n_fail++; $display("FAIL halt_write_resp: got %b expected 00", r); end
        repeat (3) step();
        n_checks++;
        if (halt !== 1'b0) begin n_fail++; $display("FAIL halt_early: got %b expected 0", halt); end
        sig_ready = 1;
        step();
        sig_ready = 0;
        axi_read(32'hF000_0008, d, r, p);
        n_checks++;
        if (d !== 32'h0000_0201) begin n_fail++; $display("FAIL status_halt: got %h expected 00000201", d); end
        axi_read(32'hF000_0000, d, r, p);
        n_checks++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL ctrl_halted: got %h expected 00000001", d); end
        axi_write(32'hF000_0004, 32'hB4, 4'hF, 0, 0, r, lat);
        n_checks++;
        if (r !== 2'b10) begin n_fail++; $display("FAIL sig_after_halt: got %b expected 10", r); end
        sig_ready = 1;
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (!sig_valid) found = 1;
            else step();
        end
        n_checks++;
        if (found !== 1'b1 || halt !== 1'b0) begin
            n_fail++; $display("FAIL halt_at_empty: empty %b halt %b expected 1/0", found, halt);
        end
        step();
        n_checks++;
        if (halt !== 1'b1) begin n_fail++; $display("FAIL halt_after_empty: got %b expected 1", halt); end
        repeat (5) step();
        n_checks++;
        if (halt !== 1'b1) begin n_fail++; $display("FAIL halt_sticky: got %b expected 1", halt); end
        n_checks++;
        if (sig_q.size() !== 3 || sig_q[0] !== 32'hB1 || sig_q[2] !== 32'hB3) begin
            n_fail++; $display("FAIL halt_drain: got %0d words expected 3 (b1..b3)", sig_q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0]  r;
        logic [31:0] d;
        bit          p;
        int          lat;
        rst = 1;
        step();
        rst = 0;
        repeat (2) step();
        sig_ready = 0;
        axi_write(32'hF000_0004, 32'hC1, 4'hF, 0, 0, r, lat);
        axi_write(32'hF000_0004, 32'hC2, 4'hF, 0, 0, r, lat);
        awaddr = 32'hF000_0004;
        wdata = 32'hC3;
        wstrb = 4'hF;
        awvalid = 1;
        wvalid = 1;
        araddr = 32'hF000_0008;
        arvalid = 1;
        step();
        awvalid = 0;
        wvalid = 0;
        arvalid = 0;
        repeat (3) step();
        n_checks++;
        if ({bvalid, rvalid, sig_valid} !== 3'b111) begin
            n_fail++; $display("FAIL pre_reset_busy: got %b expected 111", {bvalid, rvalid, sig_valid});
        end
        #3 rst = 1;
        #1;
        n_checks++;
        if ({awready, wready, bvalid, arready, rvalid, sig_valid, halt, timeout} !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_reset_flags: got %b expected 00000000",
                     {awready, wready, bvalid, arready, rvalid, sig_valid, halt, timeout});
        end
        n_checks++;
        if ({bresp, rresp, rdata} !== 36'h0) begin
            n_fail++; $display("FAIL mid_reset_data: bresp %b rresp %b rdata %h expected all 0", bresp, rresp, rdata);
        end
        step();
        rst = 0;
        repeat (2) step();
        axi_read(32'hF000_0008, d, r, p);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL post_reset_status: got %h expected 00000000", d); end
    endtask

`ifdef AXIL_SIM_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        int c = 0;
        rst = 1;
        step();
        rst = 0;
        while (!timeout && c < 300) begin
            step();
            c++;
        end
        n_checks++;
        if (c !== 100) begin n_fail++; $display("FAIL timeout_cycle: got %0d expected 100", c); end
        step();
        n_checks++;
        if (halt !== 1'b1) begin n_fail++; $display("FAIL timeout_halt: got %b expected 1", halt); end
    endtask
`endif

    initial begin
        rst = 1;
        awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
        araddr = '0; arvalid = 0; rready = 0; sig_ready = 0;
        test_reset();
`ifdef AXIL_SIM_CTRL_TIMEOUT_EN
        test_timeout();
`else
        test_sig();
        test_ordering();
        test_backpressure();
        test_decode();
        test_halt();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "bench time limit");
    end

endmodule
